// File: rtl/dac_playback.sv
// Plays NUM_SAMPLES 12-bit samples to an SPI DAC (mode 0), oldest first, one 16-bit frame each.
// Optional macro DAC_PLAYBACK_LDAC_EN: pulse LDAC low for the first GAP half-period of each frame.
module dac_playback #(
    parameter int CLK_DIV     = 500,
    parameter int NUM_SAMPLES = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [12*NUM_SAMPLES-1:0] storage,
    output logic                      CS,
    output logic                      SCK,
    output logic                      MOSI,
    output logic                      LDAC,
    output logic                      busy,
    output logic                      done,
    output logic [2:0]                o_dbg_state
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SETUP = 3'd1,
        S_SHIFT = 3'd2,
        S_GAP   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                    r_state;
    state_t                    w_next;
    logic [DIV_W-1:0]          r_div;
    logic                      r_sck;
    logic [3:0]                r_bit;
    logic [15:0]               r_shift;
    logic [12*NUM_SAMPLES-1:0] r_shadow;
    logic [IDX_W-1:0]          r_idx;
    logic                      r_gap_half;

    logic             w_tick;
    logic             w_enter_setup;
    logic             w_fall;
    logic             w_in_frame;
    logic [IDX_W-1:0] w_next_idx;
    logic [11:0]      w_sample;

    assign w_tick        = (r_div == DIV_W'(CLK_DIV - 1));
    assign w_enter_setup = (w_next == S_SETUP) && (r_state != S_SETUP);
    assign w_fall        = (r_state == S_SHIFT) && w_tick && r_sck;
    assign w_in_frame    = (r_state == S_SETUP) || (r_state == S_SHIFT);
    assign w_next_idx    = r_idx - 1'b1;
    // The first frame comes straight from storage; later frames from the shadow copy.
    assign w_sample      = (r_state == S_IDLE) ? storage[12*NUM_SAMPLES-1 -: 12]
                                               : r_shadow[int'(w_next_idx)*12 +: 12];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start) w_next = S_SETUP;
            S_SETUP: if (w_tick) w_next = S_SHIFT;
            S_SHIFT: if (w_fall && r_bit == 4'd15) w_next = S_GAP;
            S_GAP:   if (w_tick && r_gap_half) w_next = (r_idx == '0) ? S_DONE : S_SETUP;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_div      <= '0;
            r_sck      <= 1'b0;
            r_bit      <= '0;
            r_shift    <= '0;
            r_shadow   <= '0;
            r_idx      <= '0;
            r_gap_half <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_enter_setup || w_tick) begin
                r_div <= '0;
            end else begin
                r_div <= r_div + 1'b1;
            end

            if (r_state == S_SHIFT && w_tick) begin
                r_sck <= ~r_sck;
            end else if (r_state != S_SHIFT) begin
                r_sck <= 1'b0;
            end

            if (w_fall) begin
                r_bit <= r_bit + 1'b1;
            end else if (r_state != S_SHIFT) begin
                r_bit <= '0;
            end

            // MOSI advances only on SCK falling edges, so each bit straddles a rising edge.
            if (w_enter_setup) begin
                r_shift <= {4'b0011, w_sample};
            end else if (w_fall) begin
                r_shift <= {r_shift[14:0], 1'b0};
            end

            if (r_state == S_IDLE && start) begin
                r_shadow <= storage;
                r_idx    <= IDX_W'(NUM_SAMPLES - 1);
            end else if (r_state == S_GAP && w_tick && r_gap_half && r_idx != '0) begin
                r_idx <= w_next_idx;
            end

            if (r_state == S_GAP && w_tick) begin
                r_gap_half <= ~r_gap_half;
            end else if (r_state != S_GAP) begin
                r_gap_half <= 1'b0;
            end
        end
    end

    assign CS          = ~w_in_frame;
    assign SCK         = r_sck;
    assign MOSI        = w_in_frame ? r_shift[15] : 1'b0;
    assign busy        = (r_state != S_IDLE);
    assign done        = (r_state == S_DONE);
    assign o_dbg_state = r_state;

`ifdef DAC_PLAYBACK_LDAC_EN
    assign LDAC = ~((r_state == S_GAP) && !r_gap_half);
`else
    assign LDAC = 1'b0;
`endif

endmodule

// File: tb/tb_dac_playback.sv
// Scoreboard bench for dac_playback: frames captured on SCK rising edges are matched against exp_q.
module tb_dac_playback;
  localparam int CLK_DIV = 4;
  localparam int NS      = 10;
  localparam int RUN_CYC = NS * 35 * CLK_DIV;
`ifdef DAC_PLAYBACK_LDAC_EN
  localparam int EXP_LDAC_LO = CLK_DIV;
  localparam logic EXP_LDAC_IDLE = 1'b1;
`else
  localparam int EXP_LDAC_LO = 2 * CLK_DIV;
  localparam logic EXP_LDAC_IDLE = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [12*NS-1:0] storage = '0;
  logic cs, sck, mosi, ldac, busy, done;
  logic [2:0] dbg_state;

  logic [15:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  dac_playback #(.CLK_DIV(CLK_DIV), .NUM_SAMPLES(NS)) dut (
    .clk(clk), .rst(rst), .start(start), .storage(storage),
    .CS(cs), .SCK(sck), .MOSI(mosi), .LDAC(ldac), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // monitor / scoreboard
  int cyc = 0, cyc_setup = 0;
  int nbits = 0, frames_rcvd = 0, sck_rises = 0, done_seen = 0;
  int cs_hi = 0, ldac_lo = 0;
  logic gap_active = 1'b0, after_done = 1'b0;
  logic prev_sck = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0;
  logic [15:0] shreg = '0;
  logic [15:0] exp_frame;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      nbits = 0;
      gap_active = 1'b0;
      after_done = 1'b0;
      prev_busy = 1'b0;
      prev_sck = sck;
      prev_cs = cs;
    end else begin
      if (sck && !prev_sck) begin
        sck_rises++;
        if (!cs) begin
          shreg = {shreg[14:0], mosi};
          nbits++;
        end
      end
      if (cs && !prev_cs) begin
        check("cs_rise_on_sck_fall", {30'd0, prev_sck, sck}, 32'd2);
        check("bits_per_frame", nbits, 16);
        if (exp_q.size() == 0) begin
          check("unexpected_frame", shreg, 32'hFFFF_FFFF);
        end else begin
          exp_frame = exp_q.pop_front();
          check("frame_data", shreg, exp_frame);
        end
        frames_rcvd++;
        check("ldac_at_cs_rise", ldac, 0);
        gap_active = 1'b1;
        cs_hi = 1;
        ldac_lo = (ldac == 1'b0) ? 1 : 0;
      end else if (!cs && prev_cs) begin
        if (gap_active) begin
          check("cs_high_cycles", cs_hi, 2 * CLK_DIV);
          check("ldac_low_cycles", ldac_lo, EXP_LDAC_LO);
        end
        gap_active = 1'b0;
        nbits = 0;
        shreg = '0;
      end else if (cs && gap_active) begin
        cs_hi++;
        if (!ldac) ldac_lo++;
      end
      if (busy && !prev_busy) cyc_setup = cyc;
      if (done) begin
        check("done_latency", cyc - cyc_setup, RUN_CYC);
        check("busy_at_done", busy, 1);
        done_seen++;
        after_done = 1'b1;
        gap_active = 1'b0;
      end else if (after_done) begin
        check("busy_after_done", busy, 0);
        after_done = 1'b0;
      end
      prev_sck = sck;
      prev_cs = cs;
      prev_busy = busy;
    end
  end

  // driver tasks
  task automatic push_frames(input logic [12*NS-1:0] data);
    for (int i = NS - 1; i >= 0; i--) exp_q.push_back({4'b0011, data[i*12 +: 12]});
  endtask

  // Called right after a posedge; start is high for exactly one cycle.
  task automatic start_run(input logic [12*NS-1:0] data, input logic expect_run);
    #1;
    storage = data;
    start = 1'b1;
    if (expect_run) push_frames(data);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < RUN_CYC + 400 && done_seen < target; i++) @(posedge clk);
    check("done_timeout", done_seen >= target, 1);
  endtask

  task automatic wait_frames(input int target);
    for (int i = 0; i < RUN_CYC + 400 && frames_rcvd < target; i++) @(posedge clk);
    check("frames_timeout", frames_rcvd >= target, 1);
  endtask

  function automatic logic [12*NS-1:0] rand_storage();
    logic [12*NS-1:0] d;
    for (int i = 0; i < NS; i++) d[i*12 +: 12] = 12'($urandom_range(0, 4095));
    return d;
  endfunction

  logic [12*NS-1:0] data;
  int base, rises0;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_cs", cs, 1);
    check("rst_sck", sck, 0);
    check("rst_mosi", mosi, 0);
    check("rst_ldac", ldac, EXP_LDAC_IDLE);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // Run A: oldest sample 0xABC gives a first frame of 0x3ABC.
    data = rand_storage();
    data[12*NS-1 -: 12] = 12'hABC;
    check("first_frame_model", {4'b0011, data[12*NS-1 -: 12]}, 32'h3ABC);
    start_run(data, 1'b1);
    check("busy_after_start", busy, 1);
    wait_done(1);

    // Run B: ramp storage; a mid-run start with new storage must be ignored.
    repeat (5) @(posedge clk);
    for (int i = 0; i < NS; i++) data[i*12 +: 12] = 12'(i);
    start_run(data, 1'b1);
    wait_frames(frames_rcvd + 3);
    start_run(rand_storage(), 1'b0);
    wait_done(2);

    // Run C: start in the cycle after done, then abort it with reset in frame 3.
    start_run(rand_storage(), 1'b1);
    base = frames_rcvd;
    for (int i = 0; i < RUN_CYC && !(frames_rcvd == base + 2 && nbits == 8); i++) @(posedge clk);
    check("reached_frame3_bit7", (frames_rcvd == base + 2 && nbits == 8), 1);
    #1 rst = 1'b0;
    #1;
    check("abort_cs", cs, 1);
    check("abort_sck", sck, 0);
    check("abort_mosi", mosi, 0);
    check("abort_busy", busy, 0);
    check("abort_state", dbg_state, 0);
    exp_q.delete();
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    rises0 = sck_rises;
    repeat (100) @(posedge clk);
    check("no_sck_after_abort", sck_rises - rises0, 0);
    check("idle_after_abort", busy, 0);

    // Run D: a clean run after the abort.
    start_run(rand_storage(), 1'b1);
    wait_done(3);
    repeat (5) @(posedge clk);
    check("exp_q_drained", exp_q.size(), 0);
    check("total_frames", frames_rcvd, 3 * NS + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/dac_playback.md
DAC_PLAYBACK -- requirements
Module: dac_playback

Interface
REQ-001 Parameter CLK_DIV, default 500, SHALL set the number of clk cycles per SCK half-period (50 MHz clk gives a 50 kHz SCK).
REQ-002 Parameter NUM_SAMPLES, default 10, SHALL set the number of 12-bit samples played per run.
REQ-003 clk  input  1  SHALL be the single 50 MHz system clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 start  input  1  SHALL be a one-cycle-sampled request to begin playback.
REQ-006 storage  input  12*NUM_SAMPLES  SHALL be the sample buffer; the newest sample is in bits [11:0] and the oldest in the top 12 bits.
REQ-007 CS  output  1  SHALL be the DAC chip select, active-low.
REQ-008 SCK  output  1  SHALL be the SPI clock, idle low.
REQ-009 MOSI  output  1  SHALL be the serial data to the DAC, MSB first.
REQ-010 LDAC  output  1  SHALL be the DAC latch strobe, active-low.
REQ-011 busy  output  1  SHALL be high from the cycle after start is accepted until done.
REQ-012 done  output  1  SHALL pulse high for one clk cycle when the last frame completes.

Function
REQ-013 In IDLE with start=1, the block SHALL copy storage into a shadow register, set busy, and enter SETUP on the next cycle.
REQ-014 The block SHALL ignore start while busy=1; later changes to storage SHALL NOT affect a run in progress.
REQ-015 Samples SHALL be sent oldest first: index NUM_SAMPLES-1 (top 12 bits) down to index 0.
REQ-016 Each frame SHALL be 16 bits: 4'b0011 (channel A, unbuffered, 1x gain, active) followed by sample[11:0].
REQ-017 A half-period tick SHALL occur every CLK_DIV clk cycles; the divider SHALL be cleared on entry to SETUP and held at zero in IDLE.
REQ-018 SETUP SHALL drive CS low, SCK low, and MOSI equal to frame bit 15 for one half-period.
REQ-019 SHIFT SHALL toggle SCK on every tick, giving 16 rising and 16 falling edges.
REQ-020 MOSI SHALL change only on SCK falling edges (SPI mode 0); bit n SHALL be stable across the n-th rising edge.
REQ-021 CS SHALL rise on the same clk cycle as the 16th SCK falling edge, and the block SHALL then enter GAP.
REQ-022 GAP SHALL last two half-periods with CS high and SCK low; MOSI SHALL be driven low.
REQ-023 After GAP, the block SHALL enter SETUP if frames remain; otherwise it SHALL pulse done, clear busy, and return to IDLE.
REQ-024 Frame period SHALL be 35 half-periods; a default run SHALL last 10*35*500 = 175000 cycles from SETUP entry to done.
REQ-025 The states SHALL be exactly IDLE, SETUP, SHIFT, GAP, plus a one-cycle DONE state.

Reset
REQ-026 When rst=0, the block SHALL immediately (asynchronously) enter IDLE with CS=1, SCK=0, MOSI=0, LDAC=1, busy=0, done=0, and the divider, bit counter and sample index cleared.
REQ-027 Reset asserted mid-frame SHALL abort the run; no partial frame SHALL resume after reset is released.

Configuration
REQ-028 With macro DAC_PLAYBACK_LDAC_EN defined, LDAC SHALL go low for the first GAP half-period of every frame and be high at all other times.
REQ-029 Without DAC_PLAYBACK_LDAC_EN, LDAC SHALL be constant 0, so the DAC updates on the CS rising edge.

Verification (CLK_DIV=4, NUM_SAMPLES=10 unless noted)
REQ-030 Load the top 12 bits = 12'hABC and start -> the first frame on MOSI, sampled at SCK rising edges, equals 16'h3ABC.
REQ-031 Load storage with 12'h000..12'h009 (oldest=9 in the top 12 bits) and start -> frames carry data 9,8,...,0 in order; done occurs exactly 10*35*4 cycles after SETUP entry, then busy=0.
REQ-032 Pulse start mid-run and change storage -> no restart and all frames unchanged; start pulsed in the cycle after done -> a new run begins.
REQ-033 Assert rst during bit 7 of frame 3 -> the same cycle shows CS=1, SCK=0, MOSI=0, busy=0, and no SCK edges occur until the next start.
REQ-034 With DAC_PLAYBACK_LDAC_EN -> LDAC is low for 4 cycles, starting when CS rises, in every frame; without it -> LDAC is 0 throughout, and CS-high time per frame is 8 cycles.
